gpca_arb: RTL and testbench

Two-requester arbiter and sequencer for the pipelined 9-row dual-field cellular array (gpca core).
- Accepts operand sets from two clients over valid/ready handshakes and grants the single core round-robin, at most one issue per cycle.
- Registers operands into the core and tracks each in-flight operation's owner through a LAT-deep tag pipeline.
- Steers each result into the owning client's response FIFO.
- Credit-based flow control means the core is never stalled and a result is never dropped.

---
 rtl/gpca_pkg.sv | 18 +
 rtl/gpca_rsp_fifo.sv | 47 ++++
 rtl/gpca_arb.sv | 118 +++++++++++
 tb/tb_gpca_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpca_pkg.sv
// Shared widths and packed layouts for the gpca core front end.
package gpca_pkg;
  localparam int PW   = 9;
  localparam int AW   = 18;
  localparam int BW   = 19;
  localparam int SW   = 19;
  localparam int RSPW = PW + SW;

  typedef struct packed {
    logic vld;
    logic own;
  } tag_t;

  typedef struct packed {
    logic [PW-1:0] f;
    logic [SW-1:0] s;
  } rsp_t;
endpackage

// File: rtl/gpca_rsp_fifo.sv
// Response FIFO with occupancy count; head word on rd_dat (zero when empty), one cycle write-to-read.
// Write while full is legal only together with a read; the owner's credits keep it from happening otherwise.
module gpca_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);

  logic [W-1:0]    mem [DEPTH];
  logic [PTRW-1:0] wptr, rptr;
  logic            rd;

  assign rd_vld = (cnt != '0);
  assign rd     = rd_vld & rd_rdy;
  assign rd_dat = rd_vld ? mem[rptr] : '0;

  function automatic logic [PTRW-1:0] nxt(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_vld && !rst) mem[wptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_vld) wptr <= nxt(wptr);
      if (rd) rptr <= nxt(rptr);
      cnt <= cnt + CW'(wr_vld) - CW'(rd);
      assert (!(wr_vld && !rd && cnt == CW'(DEPTH)));
    end
  end
endmodule

// File: rtl/gpca_arb.sv
// Round-robin two-client front end for the gpca core; accept-to-response latency LAT+2, one issue per cycle.
// req_ready drops while a client's in-flight plus queued results reach RD, so the core never stalls.
module gpca_arb
  import gpca_pkg::*;
#(
  parameter int LAT = 9,
  parameter int RD  = 4,
  parameter int PW  = gpca_pkg::PW,
  parameter int AW  = gpca_pkg::AW,
  parameter int BW  = gpca_pkg::BW,
  parameter int SW  = gpca_pkg::SW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_x,
  input  logic [2*PW-1:0] req_p,
  input  logic [2*AW-1:0] req_a,
  input  logic [2*BW-1:0] req_b,
  input  logic [2*BW-1:0] req_c,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [2*PW-1:0] rsp_f,
  output logic [2*SW-1:0] rsp_s,
  output logic            core_issue,
  output logic            core_x,
  output logic [PW-1:0]   core_p,
  output logic [AW-1:0]   core_a,
  output logic [BW-1:0]   core_b,
  output logic [BW-1:0]   core_c,
  input  logic [PW-1:0]   core_f,
  input  logic [SW-1:0]   core_s
);
  localparam int CW  = $clog2(RD+1);
  localparam int CW1 = CW + 1;

  logic [CW-1:0] inflight [2];
  logic [CW-1:0] fifo_cnt [2];
  logic [1:0]    avail, elig, grant, ret;
  logic          rr, own;
  tag_t          issue_tag;
  tag_t          tp [LAT];

  assign avail[0] = ({1'b0, inflight[0]} + {1'b0, fifo_cnt[0]}) < CW1'(RD);
  assign avail[1] = ({1'b0, inflight[1]} + {1'b0, fifo_cnt[1]}) < CW1'(RD);
  assign elig     = req_valid & avail;

  // Reset masks the grant so nothing is accepted in the reset cycle.
  always_comb begin
    grant = elig;
    if (elig == 2'b11) grant = rr ? 2'b10 : 2'b01;
    if (rst) grant = 2'b00;
  end

  assign req_ready  = grant;
  assign own        = grant[1];
  assign core_issue = issue_tag.vld;
  assign ret[0]     = tp[LAT-1].vld & ~tp[LAT-1].own;
  assign ret[1]     = tp[LAT-1].vld &  tp[LAT-1].own;

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_tag <= '0;
      rr        <= 1'b0;
      core_x    <= 1'b0;
      core_p    <= '0;
      core_a    <= '0;
      core_b    <= '0;
      core_c    <= '0;
    end else begin
      issue_tag <= '{vld: |grant, own: own};
      if (|grant) begin
        rr     <= grant[0];
        core_x <= own ? req_x[1] : req_x[0];
        core_p <= own ? req_p[2*PW-1:PW] : req_p[PW-1:0];
        core_a <= own ? req_a[2*AW-1:AW] : req_a[AW-1:0];
        core_b <= own ? req_b[2*BW-1:BW] : req_b[BW-1:0];
        core_c <= own ? req_c[2*BW-1:BW] : req_c[BW-1:0];
      end
    end
  end

  // Owner tags trail core_issue so the last stage lines up with core_f/core_s.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tp[i] <= '0;
    end else begin
      tp[0] <= issue_tag;
      for (int i = 1; i < LAT; i++) tp[i] <= tp[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (rst) inflight[r] <= '0;
      else     inflight[r] <= inflight[r] + CW'(grant[r]) - CW'(ret[r]);
    end
  end

  for (genvar r = 0; r < 2; r++) begin : g_rsp
    logic [PW+SW-1:0] head;

    gpca_rsp_fifo #(.DEPTH(RD), .W(PW+SW)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (ret[r]),
      .wr_dat ({core_f, core_s}),
      .rd_vld (rsp_valid[r]),
      .rd_rdy (rsp_ready[r]),
      .rd_dat (head),
      .cnt    (fifo_cnt[r])
    );

    assign rsp_f[r*PW +: PW] = head[PW+SW-1:SW];
    assign rsp_s[r*SW +: SW] = head[SW-1:0];
  end
endmodule

// File: tb/tb_gpca_arb.sv
// Randomised and directed bench for gpca_arb against a LAT-cycle echo core (f=p, s=b).
// A forked monitor predicts grants from credit/round-robin rules and scoreboards responses per client.
module tb_gpca_arb;
  import gpca_pkg::*;

  localparam int LAT = 9;
  localparam int RD  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      req_valid, req_ready, req_x, rsp_valid, rsp_ready;
  logic [2*PW-1:0] req_p, rsp_f;
  logic [2*AW-1:0] req_a;
  logic [2*BW-1:0] req_b, req_c;
  logic [2*SW-1:0] rsp_s;
  logic            core_issue, core_x;
  logic [PW-1:0]   core_p, core_f;
  logic [AW-1:0]   core_a;
  logic [BW-1:0]   core_b, core_c;
  logic [SW-1:0]   core_s;

  gpca_arb #(.LAT(LAT), .RD(RD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
    .req_p(req_p), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_s(rsp_s),
    .core_issue(core_issue), .core_x(core_x), .core_p(core_p), .core_a(core_a),
    .core_b(core_b), .core_c(core_c), .core_f(core_f), .core_s(core_s)
  );

  logic [PW+BW-1:0] pipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    pipe[0] <= {core_p, core_b};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign core_f = pipe[LAT-1][PW+BW-1:BW];
  assign core_s = pipe[LAT-1][BW-1:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  logic [PW+BW-1:0] sbq [2][$];
  int               outst [2];
  logic             m_rr;
  logic [1:0]       acc;
  int               accn [2];

  logic [PW-1:0] op_p [2];
  logic [AW-1:0] op_a [2];
  logic [BW-1:0] op_b [2], op_c [2];
  logic          op_x [2];
  logic [AW-1:0] sp_a;
  logic [BW-1:0] sp_c;
  logic          sp_x;

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic new_op(int r);
    op_p[r] = PW'($urandom);
    op_a[r] = AW'($urandom);
    op_b[r] = BW'($urandom);
    op_c[r] = BW'($urandom);
    op_x[r] = 1'($urandom);
  endtask

  task automatic apply();
    for (int r = 0; r < 2; r++) begin
      req_p[r*PW +: PW] = op_p[r];
      req_a[r*AW +: AW] = op_a[r];
      req_b[r*BW +: BW] = op_b[r];
      req_c[r*BW +: BW] = op_c[r];
      req_x[r]          = op_x[r];
    end
  endtask

  task automatic step();
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
  endtask

  // Reference: credit = accepted minus popped below RD; ties go to the client not granted last.
  task automatic monitor();
    logic [1:0]       el, exp_rdy;
    logic [PW+BW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("req_ready_in_reset", req_ready, 2'b00);
        for (int r = 0; r < 2; r++) begin
          sbq[r].delete();
          outst[r] = 0;
        end
        m_rr = 1'b0;
      end else begin
        for (int r = 0; r < 2; r++) el[r] = req_valid[r] && (outst[r] < RD);
        exp_rdy = el;
        if (el == 2'b11) exp_rdy = m_rr ? 2'b10 : 2'b01;
        chk("req_ready", req_ready, exp_rdy);
        for (int r = 0; r < 2; r++) begin
          if (req_valid[r] && req_ready[r]) begin
            sbq[r].push_back({req_p[r*PW +: PW], req_b[r*BW +: BW]});
            outst[r]++;
            m_rr = (r == 0);
          end
        end
        for (int r = 0; r < 2; r++) begin
          if (rsp_valid[r]) begin
            if (sbq[r].size() == 0) begin
              chk("rsp_unexpected", rsp_valid[r], 1'b0);
            end else begin
              e = sbq[r][0];
              chk("rsp_f", rsp_f[r*PW +: PW], e[PW+BW-1:BW]);
              chk("rsp_s", rsp_s[r*SW +: SW], e[BW-1:0]);
              if (rsp_ready[r]) begin
                e = sbq[r].pop_front();
                outst[r]--;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic run(int n, logic [1:0] vfix, bit vrand, logic [1:0] rfix, bit rrand);
    for (int i = 0; i < n; i++) begin
      req_valid = vrand ? 2'($urandom) : vfix;
      rsp_ready = rrand ? 2'($urandom) : rfix;
      apply();
      step();
      for (int r = 0; r < 2; r++) begin
        if (acc[r]) begin
          accn[r]++;
          new_op(r);
        end
      end
    end
    req_valid = 2'b00;
    apply();
  endtask

  task automatic drain(string name);
    run(3 * (LAT + 2), 2'b00, 1'b0, 2'b11, 1'b0);
    chk(name, sbq[0].size() + sbq[1].size(), 0);
  endtask

  task automatic single_op(string name);
    int t0, lat;
    rsp_ready = 2'b11;
    op_p[0] = 9'h1A5;
    op_b[0] = 19'h4_0001;
    sp_a = op_a[0];
    sp_c = op_c[0];
    sp_x = op_x[0];
    req_valid = 2'b01;
    apply();
    t0 = cyc;
    step();
    chk({name, "_accept"}, acc, 2'b01);
    req_valid = 2'b00;
    new_op(0);
    apply();
    chk({name, "_core_issue"}, core_issue, 1'b1);
    chk({name, "_core_ops"}, {core_x, core_p, core_a, core_b, core_c},
        {sp_x, 9'h1A5, sp_a, 19'h4_0001, sp_c});
    lat = -1;
    for (int k = 0; k < 3 * LAT; k++) begin
      if (rsp_valid != 2'b00) begin
        lat = cyc - t0;
        break;
      end
      step();
    end
    chk({name, "_latency"}, lat, LAT + 2);
    chk({name, "_valid_bits"}, rsp_valid, 2'b01);
    chk({name, "_f_s"}, {rsp_f[PW-1:0], rsp_s[SW-1:0]}, {9'h1A5, 19'h4_0001});
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    for (int r = 0; r < 2; r++) begin
      new_op(r);
      accn[r] = 0;
      outst[r] = 0;
    end
    m_rr = 1'b0;
    apply();
    fork
      monitor();
    join_none
    repeat (3) step();
    chk("reset_core", {core_issue, core_x, core_p, core_a, core_b, core_c}, '0);
    chk("reset_rsp", {rsp_valid, rsp_f, rsp_s}, '0);
    rst = 1'b0;
    run(2, 2'b00, 1'b0, 2'b00, 1'b0);

    single_op("single");
    drain("single_drain");

    accn = '{0, 0};
    run(40, 2'b11, 1'b0, 2'b11, 1'b0);
    chk("contend_balance", (accn[0] - accn[1] <= 1) && (accn[1] - accn[0] <= 1), 1'b1);
    drain("contend_drain");

    accn = '{0, 0};
    run(30, 2'b01, 1'b0, 2'b00, 1'b0);
    chk("stall_accepts", accn[0], RD);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    #1;
    chk("stall_ready", req_ready, 2'b00);
    accn = '{0, 0};
    run(1, 2'b01, 1'b0, 2'b01, 1'b0);
    run(20, 2'b01, 1'b0, 2'b00, 1'b0);
    chk("stall_one_more", accn[0], 1);

    accn = '{0, 0};
    run(40, 2'b01, 1'b0, 2'b01, 1'b0);
    chk("full_stream_progress", accn[0] >= 8, 1'b1);
    drain("full_drain");

    accn = '{0, 0};
    for (int i = 0; i < 10 && (accn[0] + accn[1]) < 3; i++)
      run(1, 2'b11, 1'b0, 2'b11, 1'b0);
    chk("pre_reset_accepts", accn[0] + accn[1], 3);
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    step();
    rst = 1'b0;
    req_valid = 2'b00;
    chk("midreset_core", {core_issue, core_x, core_p, core_a, core_b, core_c}, '0);
    chk("midreset_rsp", {rsp_valid, rsp_f, rsp_s}, '0);
    run(2 * (LAT + 2), 2'b00, 1'b0, 2'b11, 1'b0);
    single_op("post_reset");

    for (int i = 0; i < 20; i++) begin
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      step();
      chk("idle_issue", core_issue, 1'b0);
      chk("idle_hold", {core_x, core_p, core_a, core_b, core_c},
          {sp_x, 9'h1A5, sp_a, 19'h4_0001, sp_c});
    end

    run(400, 2'b00, 1'b1, 2'b00, 1'b1);
    drain("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
